// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the byte-serial memory port arbiter.
// Size codes match the pipeline's existing sub-word encoding.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_e;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  // Size code 3 is treated as a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_SIZE_BYTE: size_bytes = 3'd1;
      MEM_SIZE_HALF: size_bytes = 3'd2;
      default:       size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection: fixed priority (highest index wins) or
// round-robin search starting at the pointer and wrapping at N_CH.
module mem_port_arbiter_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ARB_RR = 0,
  parameter int PTR_W  = 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_CH-1:0]  win
);

  logic found;
  int   idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (ARB_RR != 0) idx = (int'(ptr) + i) % N_CH;
      else             idx = N_CH - 1 - i;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter and byte-serial sequencer for the 8-bit RAM/IO bus.
// Reads take n+1 cycles (one-cycle RAM latency), writes take n cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int              N_CH       = 2,
  parameter int              ARB_RR     = 0,
  parameter logic [N_CH-1:0] FLUSH_MASK = N_CH'(1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                flush,
  input  logic [N_CH-1:0]     ch_req,
  input  logic [N_CH-1:0]     ch_we,
  input  logic [N_CH*32-1:0]  ch_addr,
  input  logic [N_CH*2-1:0]   ch_size,
  input  logic [N_CH-1:0]     ch_signed,
  input  logic [N_CH*32-1:0]  ch_wdata,
  output logic [N_CH-1:0]     ch_done,
  output logic [N_CH-1:0]     ch_gnt,
  output logic [31:0]         rdata,
  input  logic [7:0]          mem_din,
  output logic [7:0]          mem_dout,
  output logic [31:0]         mem_a,
  output logic                mem_wr
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] owner_q, ptr_q, win_idx;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [1:0]       size_q;
  logic             we_q, sgn_q;
  logic [2:0]       k_q, n_q;
  logic [23:0]      cap_q;
  logic [N_CH-1:0]  done_q, elig, win;
  logic             grant, abort, last;

  function automatic logic [31:0] extend_read(input logic [1:0] size, input logic sgn,
                                              input logic [23:0] cap, input logic [7:0] top);
    case (size)
      MEM_SIZE_BYTE: extend_read = {{24{sgn & top[7]}}, top};
      MEM_SIZE_HALF: extend_read = {{16{sgn & top[7]}}, top, cap[7:0]};
      default:       extend_read = {top, cap};
    endcase
  endfunction

  // The channel completing this cycle is masked so a lingering request is not regranted.
  assign elig = ch_req & ~done_q & ~(flush ? FLUSH_MASK : '0);

  mem_port_arbiter_pick #(
    .N_CH   (N_CH),
    .ARB_RR (ARB_RR),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req (elig),
    .ptr (ptr_q),
    .win (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (win[i]) win_idx = PTR_W'(i);
  end

  assign grant = (state_q == ARB_IDLE) && (|win);
  assign abort = (state_q == ARB_ACCESS) && flush && !we_q && FLUSH_MASK[owner_q];
  assign last  = we_q ? (k_q == n_q - 3'd1) : (k_q == n_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy) begin
      case (state_q)
        ARB_IDLE:   if (|win) state_d = ARB_ACCESS;
        ARB_ACCESS: if (abort || last) state_d = ARB_IDLE;
        default:    state_d = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    ch_gnt   = '0;
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    if (state_q == ARB_ACCESS) begin
      ch_gnt[owner_q] = 1'b1;
      mem_a           = addr_q + 32'(k_q);
      mem_wr          = we_q & rdy;
      if (we_q) begin
        case (k_q[1:0])
          2'd0:    mem_dout = wdata_q[7:0];
          2'd1:    mem_dout = wdata_q[15:8];
          2'd2:    mem_dout = wdata_q[23:16];
          default: mem_dout = wdata_q[31:24];
        endcase
      end
    end
  end

  // Control: byte counter, completion pulse, RR pointer, read result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q     <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else if (rdy) begin
      done_q <= '0;
      if (grant) begin
        k_q <= '0;
        if (ARB_RR != 0)
          ptr_q <= (win_idx == PTR_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
      end else if (state_q == ARB_ACCESS && !abort) begin
        if (last) begin
          done_q[owner_q] <= 1'b1;
          if (!we_q) rdata_q <= extend_read(size_q, sgn_q, cap_q, mem_din);
        end else begin
          k_q <= k_q + 3'd1;
        end
      end
    end
  end

  // Datapath captures: request fields at grant, read bytes as they arrive.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (grant) begin
        owner_q <= win_idx;
        addr_q  <= ch_addr[32*win_idx +: 32];
        wdata_q <= ch_wdata[32*win_idx +: 32];
        size_q  <= ch_size[2*win_idx +: 2];
        n_q     <= size_bytes(ch_size[2*win_idx +: 2]);
        we_q    <= ch_we[win_idx];
        sgn_q   <= ch_signed[win_idx];
      end else if (state_q == ARB_ACCESS && !we_q && !last) begin
        case (k_q)
          3'd1:    cap_q[7:0]   <= mem_din;
          3'd2:    cap_q[15:8]  <= mem_din;
          3'd3:    cap_q[23:16] <= mem_din;
          default: ;
        endcase
      end
    end
  end

  assign ch_done = done_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a fixed-priority instance and a round-robin
// instance share the channel fields, each with its own request vector and RAM read port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic [1:0]  fp_req, rr_req, ch_we, ch_signed;
  logic [63:0] ch_addr, ch_wdata;
  logic [3:0]  ch_size;
  logic [1:0]  fp_done, fp_gnt, rr_done, rr_gnt;
  logic [31:0] fp_rdata, rr_rdata, fp_a, rr_a;
  logic [7:0]  fp_din, rr_din, fp_dout, rr_dout;
  logic        fp_wr, rr_wr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_CH(2), .ARB_RR(0), .FLUSH_MASK(2'b01)) dut_fp (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .ch_req(fp_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_size(ch_size),
    .ch_signed(ch_signed), .ch_wdata(ch_wdata), .ch_done(fp_done), .ch_gnt(fp_gnt),
    .rdata(fp_rdata), .mem_din(fp_din), .mem_dout(fp_dout), .mem_a(fp_a), .mem_wr(fp_wr)
  );

  mem_port_arbiter #(.N_CH(2), .ARB_RR(1), .FLUSH_MASK(2'b01)) dut_rr (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .ch_req(rr_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_size(ch_size),
    .ch_signed(ch_signed), .ch_wdata(ch_wdata), .ch_done(rr_done), .ch_gnt(rr_gnt),
    .rdata(rr_rdata), .mem_din(rr_din), .mem_dout(rr_dout), .mem_a(rr_a), .mem_wr(rr_wr)
  );

  // Synchronous RAM, one-cycle read latency; read contents reloaded while in reset.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h00; ram[12'h102] <= 8'h00; ram[12'h103] <= 8'h00;
      ram[12'h104] <= 8'h11; ram[12'h105] <= 8'h22; ram[12'h106] <= 8'h33; ram[12'h107] <= 8'h44;
      ram[12'h200] <= 8'h80; ram[12'h201] <= 8'h55; ram[12'h202] <= 8'h34; ram[12'h203] <= 8'h92;
    end else if (fp_wr) begin
      ram[fp_a[11:0]] <= fp_dout;
    end
    fp_din <= ram[fp_a[11:0]];
    rr_din <= ram[rr_a[11:0]];
  end

  int          wcnt = 0;
  logic [7:0]  wlog_d [0:63];
  logic [31:0] wlog_a [0:63];
  always @(posedge clk) begin
    if (fp_wr === 1'b1) begin
      wlog_d[wcnt % 64] <= fp_dout;
      wlog_a[wcnt % 64] <= fp_a;
      wcnt <= wcnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    ch_we[ch]            = we;
    ch_size[2*ch +: 2]   = size;
    ch_signed[ch]        = sgn;
    ch_addr[32*ch +: 32] = addr;
    ch_wdata[32*ch +: 32] = wdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (fp_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", fp_gnt); end
    n_checks++; if (fp_done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", fp_done); end
    n_checks++; if (fp_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", fp_a); end
    n_checks++; if (fp_wr !== 1'b0 || rr_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b/%b want 0/0", fp_wr, rr_wr); end
    n_checks++; if (fp_dout !== 8'h0 || rr_dout !== 8'h0) begin n_fail++; $display("FAIL reset_dout: got %h/%h want 00/00", fp_dout, rr_dout); end
    n_checks++; if (fp_rdata !== 32'h0 || rr_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", fp_rdata, rr_rdata); end
    n_checks++; if (rr_gnt !== 2'b00 || rr_done !== 2'b00) begin n_fail++; $display("FAIL reset_rr: gnt %b done %b want 00", rr_gnt, rr_done); end
    rst_n = 1'b1;
  endtask

  task automatic test_word_read();
    set_ch(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    fp_req = 2'b01;
    tick();
    n_checks++; if (fp_gnt !== 2'b01) begin n_fail++; $display("FAIL word_gnt: got %b want 01", fp_gnt); end
    n_checks++; if (fp_a !== 32'h100 || fp_wr !== 1'b0) begin n_fail++; $display("FAIL word_a0: got %h wr %b want 100 wr 0", fp_a, fp_wr); end
    tick();
    n_checks++; if (fp_a !== 32'h101) begin n_fail++; $display("FAIL word_a1: got %h want 101", fp_a); end
    tick();
    n_checks++; if (fp_a !== 32'h102) begin n_fail++; $display("FAIL word_a2: got %h want 102", fp_a); end
    tick();
    n_checks++; if (fp_a !== 32'h103) begin n_fail++; $display("FAIL word_a3: got %h want 103", fp_a); end
    tick();
    n_checks++; if (fp_done !== 2'b00) begin n_fail++; $display("FAIL word_early_done: got %b want 00", fp_done); end
    tick();
    n_checks++; if (fp_done !== 2'b01) begin n_fail++; $display("FAIL word_done: got %b want 01", fp_done); end
    n_checks++; if (fp_rdata !== 32'h00000013) begin n_fail++; $display("FAIL word_rdata: got %h want 00000013", fp_rdata); end
    n_checks++; if (fp_gnt !== 2'b00) begin n_fail++; $display("FAIL word_idle_gnt: got %b want 00", fp_gnt); end
    fp_req = 2'b00;
    tick();
    n_checks++; if (fp_done !== 2'b00) begin n_fail++; $display("FAIL word_done_pulse: got %b want 00", fp_done); end
    set_ch(0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    fp_req = 2'b01;
    repeat (6) tick();
    n_checks++; if (fp_done !== 2'b01 || fp_rdata !== 32'h44332211) begin n_fail++; $display("FAIL word_order: done %b rdata %h want 01 44332211", fp_done, fp_rdata); end
    fp_req = 2'b00;
    tick();
  endtask

  task automatic test_sub_word();
    set_ch(1, 1'b0, 2'd0, 1'b1, 32'h200, 32'h0);
    fp_req = 2'b10;
    tick(); tick();
    n_checks++; if (fp_done !== 2'b00) begin n_fail++; $display("FAIL byte_early_done: got %b want 00", fp_done); end
    tick();
    n_checks++; if (fp_done !== 2'b10 || fp_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_signed: done %b rdata %h want 10 ffffff80", fp_done, fp_rdata); end
    fp_req = 2'b00;
    tick();
    set_ch(1, 1'b0, 2'd0, 1'b0, 32'h200, 32'h0);
    fp_req = 2'b10;
    repeat (3) tick();
    n_checks++; if (fp_done !== 2'b10 || fp_rdata !== 32'h00000080) begin n_fail++; $display("FAIL byte_unsigned: done %b rdata %h want 10 00000080", fp_done, fp_rdata); end
    fp_req = 2'b00;
    tick();
    set_ch(1, 1'b0, 2'd1, 1'b1, 32'h202, 32'h0);
    fp_req = 2'b10;
    repeat (4) tick();
    n_checks++; if (fp_done !== 2'b10 || fp_rdata !== 32'hFFFF9234) begin n_fail++; $display("FAIL half_signed: done %b rdata %h want 10 ffff9234", fp_done, fp_rdata); end
    fp_req = 2'b00;
    tick();
  endtask

  task automatic test_fixed_priority();
    set_ch(0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    set_ch(1, 1'b0, 2'd0, 1'b0, 32'h200, 32'h0);
    fp_req = 2'b11;
    tick();
    n_checks++; if (fp_gnt !== 2'b10) begin n_fail++; $display("FAIL fp_first: got %b want 10", fp_gnt); end
    tick(); tick();
    n_checks++; if (fp_done !== 2'b10 || fp_rdata !== 32'h80) begin n_fail++; $display("FAIL fp_ch1_done: done %b rdata %h want 10 00000080", fp_done, fp_rdata); end
    fp_req = 2'b01;
    tick();
    n_checks++; if (fp_gnt !== 2'b01) begin n_fail++; $display("FAIL fp_back_to_back: got %b want 01", fp_gnt); end
    repeat (4) tick();
    n_checks++; if (fp_done !== 2'b00) begin n_fail++; $display("FAIL fp_ch0_early: got %b want 00", fp_done); end
    tick();
    n_checks++; if (fp_done !== 2'b01 || fp_rdata !== 32'h44332211) begin n_fail++; $display("FAIL fp_ch0_done: done %b rdata %h want 01 44332211", fp_done, fp_rdata); end
    fp_req = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    set_ch(0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    fp_req = 2'b01;
    repeat (3) tick();
    n_checks++; if (fp_done !== 2'b01 || fp_rdata !== 32'h13) begin n_fail++; $display("FAIL b2b_done: done %b rdata %h want 01 00000013", fp_done, fp_rdata); end
    tick();
    n_checks++; if (fp_gnt !== 2'b00 || fp_done !== 2'b00) begin n_fail++; $display("FAIL b2b_mask: gnt %b done %b want 00 00", fp_gnt, fp_done); end
    fp_req = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    set_ch(0, 1'b0, 2'd0, 1'b0, 32'h200, 32'h0);
    set_ch(1, 1'b0, 2'd0, 1'b0, 32'h201, 32'h0);
    rr_req = 2'b01;
    tick();
    n_checks++; if (rr_gnt !== 2'b01) begin n_fail++; $display("FAIL rr_prime: got %b want 01", rr_gnt); end
    tick(); tick();
    rr_req = 2'b00;
    tick();
    rr_req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_g = (g % 2 == 0) ? 2'b10 : 2'b01;
      exp_d = (g % 2 == 0) ? 32'h55 : 32'h80;
      tick();
      n_checks++; if (rr_gnt !== exp_g) begin n_fail++; $display("FAIL rr_alt%0d: got %b want %b", g, rr_gnt, exp_g); end
      tick(); tick();
      n_checks++; if (rr_done !== exp_g || rr_rdata !== exp_d) begin n_fail++; $display("FAIL rr_done%0d: done %b rdata %h want %b %h", g, rr_done, rr_rdata, exp_g, exp_d); end
    end
    rr_req = 2'b00;
    tick();
    rr_req = 2'b10;
    tick(); tick(); tick();
    rr_req = 2'b00;
    tick();
    rr_req = 2'b11;
    tick();
    n_checks++; if (rr_gnt !== 2'b01) begin n_fail++; $display("FAIL rr_pointer: got %b want 01", rr_gnt); end
    tick(); tick();
    rr_req = 2'b00;
    tick();
  endtask

  task automatic test_flush();
    int base;
    set_ch(0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    set_ch(1, 1'b1, 2'd2, 1'b0, 32'h300, 32'hA1B2C3D4);
    fp_req = 2'b01;
    tick();
    n_checks++; if (fp_gnt !== 2'b01) begin n_fail++; $display("FAIL flush_gnt: got %b want 01", fp_gnt); end
    fp_req = 2'b11;
    tick(); tick();
    flush = 1'b1;
    tick();
    n_checks++; if (fp_gnt !== 2'b00 || fp_done !== 2'b00) begin n_fail++; $display("FAIL flush_abort: gnt %b done %b want 00 00", fp_gnt, fp_done); end
    n_checks++; if (fp_rdata !== 32'h13) begin n_fail++; $display("FAIL flush_rdata: got %h want 00000013", fp_rdata); end
    flush  = 1'b0;
    fp_req = 2'b10;
    base   = wcnt;
    tick();
    n_checks++; if (fp_gnt !== 2'b10 || fp_done !== 2'b00) begin n_fail++; $display("FAIL flush_next: gnt %b done %b want 10 00", fp_gnt, fp_done); end
    n_checks++; if (fp_wr !== 1'b1 || fp_dout !== 8'hD4 || fp_a !== 32'h300) begin n_fail++; $display("FAIL wr_byte0: wr %b dout %h a %h want 1 d4 300", fp_wr, fp_dout, fp_a); end
    tick(); tick(); tick();
    n_checks++; if (fp_dout !== 8'hA1 || fp_a !== 32'h303) begin n_fail++; $display("FAIL wr_byte3: dout %h a %h want a1 303", fp_dout, fp_a); end
    tick();
    n_checks++; if (fp_done !== 2'b10 || fp_rdata !== 32'h13) begin n_fail++; $display("FAIL wr_done: done %b rdata %h want 10 00000013", fp_done, fp_rdata); end
    fp_req = 2'b00;
    tick();
    n_checks++; if (wcnt - base !== 4) begin n_fail++; $display("FAIL wr_count: got %0d want 4", wcnt - base); end
    n_checks++;
    if ({wlog_d[base+3], wlog_d[base+2], wlog_d[base+1], wlog_d[base]} !== 32'hA1B2C3D4) begin
      n_fail++; $display("FAIL wr_bytes: got %h want a1b2c3d4", {wlog_d[base+3], wlog_d[base+2], wlog_d[base+1], wlog_d[base]});
    end
  endtask

  task automatic test_rdy_stall();
    int base;
    set_ch(1, 1'b1, 2'd1, 1'b0, 32'h30000, 32'h0000BEEF);
    fp_req = 2'b10;
    base   = wcnt;
    tick();
    n_checks++; if (fp_wr !== 1'b1 || fp_dout !== 8'hEF || fp_a !== 32'h30000) begin n_fail++; $display("FAIL stall_b0: wr %b dout %h a %h want 1 ef 30000", fp_wr, fp_dout, fp_a); end
    tick();
    rdy = 1'b0;
    #1;
    n_checks++; if (fp_wr !== 1'b0 || fp_a !== 32'h30001) begin n_fail++; $display("FAIL stall_enter: wr %b a %h want 0 30001", fp_wr, fp_a); end
    tick(); tick();
    n_checks++; if (fp_wr !== 1'b0 || fp_a !== 32'h30001 || fp_gnt !== 2'b10 || fp_done !== 2'b00) begin
      n_fail++; $display("FAIL stall_hold: wr %b a %h gnt %b done %b want 0 30001 10 00", fp_wr, fp_a, fp_gnt, fp_done);
    end
    tick();
    rdy = 1'b1;
    #1;
    n_checks++; if (fp_wr !== 1'b1 || fp_dout !== 8'hBE || fp_a !== 32'h30001) begin n_fail++; $display("FAIL stall_b1: wr %b dout %h a %h want 1 be 30001", fp_wr, fp_dout, fp_a); end
    tick();
    n_checks++; if (fp_done !== 2'b10) begin n_fail++; $display("FAIL stall_done: got %b want 10", fp_done); end
    fp_req = 2'b00;
    tick();
    n_checks++; if (wcnt - base !== 2) begin n_fail++; $display("FAIL stall_pulses: got %0d want 2", wcnt - base); end
    n_checks++; if (wlog_d[base] !== 8'hEF || wlog_d[base+1] !== 8'hBE || wlog_a[base+1] !== 32'h30001) begin
      n_fail++; $display("FAIL stall_log: %h %h @%h want ef be @30001", wlog_d[base], wlog_d[base+1], wlog_a[base+1]);
    end
  endtask

  task automatic test_reset_mid();
    set_ch(0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    fp_req = 2'b01;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    n_checks++; if (fp_gnt !== 2'b00 || fp_a !== 32'h0 || fp_wr !== 1'b0 || fp_done !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_outs: gnt %b a %h wr %b done %b want all 0", fp_gnt, fp_a, fp_wr, fp_done);
    end
    n_checks++; if (fp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0", fp_rdata); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (fp_gnt !== 2'b01) begin n_fail++; $display("FAIL rst_fresh_gnt: got %b want 01", fp_gnt); end
    repeat (4) tick();
    n_checks++; if (fp_done !== 2'b00) begin n_fail++; $display("FAIL rst_fresh_early: got %b want 00", fp_done); end
    tick();
    n_checks++; if (fp_done !== 2'b01 || fp_rdata !== 32'h44332211) begin n_fail++; $display("FAIL rst_fresh_done: done %b rdata %h want 01 44332211", fp_done, fp_rdata); end
    fp_req = 2'b00;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    rdy       = 1'b1;
    flush     = 1'b0;
    fp_req    = 2'b00;
    rr_req    = 2'b00;
    ch_we     = 2'b00;
    ch_signed = 2'b00;
    ch_size   = 4'b0;
    ch_addr   = 64'h0;
    ch_wdata  = 64'h0;
    test_reset();
    test_word_read();
    test_sub_word();
    test_fixed_priority();
    test_back_to_back();
    test_round_robin();
    test_flush();
    test_rdy_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
